// File: rtl/pipeline_pkg.sv
// Shared widths and encodings for the MEM/WB write-back path.
package pipeline_pkg;
    localparam int   DATA_W_DFLT  = 32;
    localparam int   ADDR_W_DFLT  = 5;
    localparam int   EXT_W_DFLT   = 16;
    localparam int   CNT_W        = 16;
    localparam int   REG_ZERO     = 0;
    localparam logic MEMTOREG_MEM = 1'b1;
    localparam logic MEMTOREG_ALU = 1'b0;
endpackage

// File: rtl/wb_regfile_if.sv
// MEM/WB write-back controls plus ID-stage read ports.
interface wb_regfile_if
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT
);
    logic              RegWrite_i;
    logic              MemtoReg_i;
    logic              ExtOp_i;
    logic [DATA_W-1:0] Read_data_i;
    logic [DATA_W-1:0] ALUdata_i;
    logic [ADDR_W-1:0] instr_i;
    logic [ADDR_W-1:0] RS_addr_i;
    logic [ADDR_W-1:0] RT_addr_i;
    logic [DATA_W-1:0] RS_data_o;
    logic [DATA_W-1:0] RT_data_o;
    logic [DATA_W-1:0] WB_data_o;
    logic              WB_valid_o;
    logic [CNT_W-1:0]  wr_count_o;

    modport master (
        output RegWrite_i, MemtoReg_i, ExtOp_i,
        output Read_data_i, ALUdata_i, instr_i,
        output RS_addr_i, RT_addr_i,
        input  RS_data_o, RT_data_o,
        input  WB_data_o, WB_valid_o, wr_count_o
    );

    modport slave (
        input  RegWrite_i, MemtoReg_i, ExtOp_i,
        input  Read_data_i, ALUdata_i, instr_i,
        input  RS_addr_i, RT_addr_i,
        output RS_data_o, RT_data_o,
        output WB_data_o, WB_valid_o, wr_count_o
    );
endinterface

// File: rtl/wb_regfile_select.sv
// Write-back source mux with optional sign extension of load data.
module wb_select
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int EXT_W  = EXT_W_DFLT
) (
    input  logic              i_memtoreg,
    input  logic              i_ext_op,
    input  logic [DATA_W-1:0] i_read_data,
    input  logic [DATA_W-1:0] i_alu_data,
    output logic [DATA_W-1:0] o_wb_data
);
    logic [DATA_W-1:0] w_ld;

    assign w_ld = i_ext_op
        ? {{(DATA_W-EXT_W){i_read_data[EXT_W-1]}},
           i_read_data[EXT_W-1:0]}
        : i_read_data;

    assign o_wb_data = (i_memtoreg == MEMTOREG_MEM)
        ? w_ld : i_alu_data;
endmodule

// File: rtl/wb_regfile.sv
// 32x32 register file fed by MEM/WB, with write-through read bypass.
module wb_regfile
    import pipeline_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT,
    parameter int ADDR_W = ADDR_W_DFLT,
    parameter int EXT_W  = EXT_W_DFLT
) (
    input  logic        clk_i,
    input  logic        rst_i,
    wb_regfile_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_A = ADDR_W'(REG_ZERO);

    logic [DATA_W-1:0] r_regs [DEPTH];
    logic [CNT_W-1:0]  r_wr_count;
    logic [DATA_W-1:0] w_wb_data;
    logic              w_wb_valid;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    wb_select #(
        .DATA_W (DATA_W),
        .EXT_W  (EXT_W)
    ) u_select (
        .i_memtoreg  (bus.MemtoReg_i),
        .i_ext_op    (bus.ExtOp_i),
        .i_read_data (bus.Read_data_i),
        .i_alu_data  (bus.ALUdata_i),
        .o_wb_data   (w_wb_data)
    );

    assign w_wb_valid = bus.RegWrite_i && (bus.instr_i != ZERO_A);

    // Entry 0 is cleared by reset and never written, so it stays 0.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (w_wb_valid) begin
            r_regs[bus.instr_i] <= w_wb_data;
            r_wr_count          <= r_wr_count + 1'b1;
        end
    end

    always_comb begin
        w_rs_data = r_regs[bus.RS_addr_i];
        if (bus.RS_addr_i == ZERO_A) begin
            w_rs_data = '0;
        end else if (w_wb_valid && bus.RS_addr_i == bus.instr_i) begin
            w_rs_data = w_wb_data;
        end
    end

    always_comb begin
        w_rt_data = r_regs[bus.RT_addr_i];
        if (bus.RT_addr_i == ZERO_A) begin
            w_rt_data = '0;
        end else if (w_wb_valid && bus.RT_addr_i == bus.instr_i) begin
            w_rt_data = w_wb_data;
        end
    end

    assign bus.RS_data_o  = w_rs_data;
    assign bus.RT_data_o  = w_rt_data;
    assign bus.WB_data_o  = w_wb_data;
    assign bus.WB_valid_o = w_wb_valid;
    assign bus.wr_count_o = r_wr_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed vector bench for wb_regfile.
module tb_wb_regfile;
    import pipeline_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    wb_regfile_if bus ();

    wb_regfile u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic        m2r;
        logic        ext;
        logic [31:0] rd;
        logic [31:0] alu;
        logic [4:0]  dst;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] e_wb;
        logic        e_valid;
        logic [31:0] e_rs;
        logic [31:0] e_rt;
    } vec_t;

    vec_t vecs [13];
    logic [15:0] cnt_model;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic we, input logic m2r,
                         input logic ext, input logic [31:0] rd,
                         input logic [31:0] alu, input logic [4:0] dst,
                         input logic [4:0] rs, input logic [4:0] rt);
        bus.RegWrite_i  = we;
        bus.MemtoReg_i  = m2r;
        bus.ExtOp_i     = ext;
        bus.Read_data_i = rd;
        bus.ALUdata_i   = alu;
        bus.instr_i     = dst;
        bus.RS_addr_i   = rs;
        bus.RT_addr_i   = rt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        vecs[0]  = '{1, 0, 0, 32'h0, 32'h1234_5678, 5, 5, 0,
                     32'h1234_5678, 1, 32'h1234_5678, 32'h0};
        vecs[1]  = '{0, 0, 0, 32'h0, 32'h0, 5, 5, 5,
                     32'h0, 0, 32'h1234_5678, 32'h1234_5678};
        vecs[2]  = '{1, 1, 1, 32'h0000_8001, 32'hAAAA_AAAA, 7, 7, 5,
                     32'hFFFF_8001, 1, 32'hFFFF_8001, 32'h1234_5678};
        vecs[3]  = '{0, 0, 0, 32'h0, 32'h0, 0, 7, 7,
                     32'h0, 0, 32'hFFFF_8001, 32'hFFFF_8001};
        vecs[4]  = '{1, 1, 0, 32'h0000_8001, 32'h0, 7, 0, 1,
                     32'h0000_8001, 1, 32'h0, 32'h0};
        vecs[5]  = '{0, 0, 0, 32'h0, 32'h0, 0, 7, 7,
                     32'h0, 0, 32'h0000_8001, 32'h0000_8001};
        vecs[6]  = '{1, 0, 0, 32'h0, 32'hFFFF_FFFF, 0, 0, 0,
                     32'hFFFF_FFFF, 0, 32'h0, 32'h0};
        vecs[7]  = '{0, 0, 0, 32'h0, 32'h0, 0, 0, 5,
                     32'h0, 0, 32'h0, 32'h1234_5678};
        vecs[8]  = '{1, 0, 0, 32'h0, 32'h1111_1111, 9, 9, 9,
                     32'h1111_1111, 1, 32'h1111_1111, 32'h1111_1111};
        vecs[9]  = '{1, 0, 0, 32'h0, 32'hDEAD_BEEF, 9, 9, 9,
                     32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[10] = '{0, 0, 0, 32'h0, 32'h0, 0, 9, 9,
                     32'h0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        vecs[11] = '{1, 1, 1, 32'hFFFF_7FFF, 32'h0, 31, 31, 30,
                     32'h0000_7FFF, 1, 32'h0000_7FFF, 32'h0};
        vecs[12] = '{0, 0, 0, 32'h0, 32'h0, 0, 31, 9,
                     32'h0, 0, 32'h0000_7FFF, 32'hDEAD_BEEF};

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 5, 7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_count", 32'(bus.wr_count_o), 32'h0);
        chk("reset_rs5", bus.RS_data_o, 32'h0);
        chk("reset_rt7", bus.RT_data_o, 32'h0);

        cnt_model = 16'h0;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].we, vecs[i].m2r, vecs[i].ext, vecs[i].rd,
                  vecs[i].alu, vecs[i].dst, vecs[i].rs, vecs[i].rt);
            #1;
            chk($sformatf("v%0d_wb", i), bus.WB_data_o, vecs[i].e_wb);
            chk($sformatf("v%0d_valid", i), 32'(bus.WB_valid_o),
                32'(vecs[i].e_valid));
            chk($sformatf("v%0d_rs", i), bus.RS_data_o, vecs[i].e_rs);
            chk($sformatf("v%0d_rt", i), bus.RT_data_o, vecs[i].e_rt);
            chk($sformatf("v%0d_cnt", i), 32'(bus.wr_count_o),
                32'(cnt_model));
            @(posedge clk);
            if (vecs[i].e_valid) cnt_model = cnt_model + 16'd1;
        end

        // Reset wins over a simultaneous write to r3; bypass still live.
        @(negedge clk);
        rst = 1'b1;
        drive(1, 0, 0, 0, 32'h3333_3333, 3, 3, 3);
        #1;
        chk("rst_bypass_rs", bus.RS_data_o, 32'h3333_3333);
        chk("rst_valid", 32'(bus.WB_valid_o), 32'h1);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int a = 0; a < 32; a++) begin
            bus.RS_addr_i = 5'(a);
            bus.RT_addr_i = 5'(31 - a);
            #1;
            chk($sformatf("clr_rs%0d", a), bus.RS_data_o, 32'h0);
            chk($sformatf("clr_rt%0d", 31 - a), bus.RT_data_o, 32'h0);
        end
        chk("clr_count", 32'(bus.wr_count_o), 32'h0);

        // Counter wrap after 65536 commits.
        for (int i = 0; i < 65535; i++) begin
            @(negedge clk);
            drive(1, 0, 0, 0, 32'(i), 1, 0, 0);
            @(posedge clk);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 1, 0);
        #1;
        chk("cnt_ffff", 32'(bus.wr_count_o), 32'h0000_FFFF);
        chk("last_r1", bus.RS_data_o, 32'd65534);
        @(negedge clk);
        drive(1, 0, 0, 0, 32'h0000_CAFE, 2, 0, 0);
        @(posedge clk);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 2, 1);
        #1;
        chk("cnt_wrap", 32'(bus.wr_count_o), 32'h0);
        chk("wrap_r2", bus.RS_data_o, 32'h0000_CAFE);
        chk("wrap_r1", bus.RT_data_o, 32'd65534);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
